cmd_draw_edges: RTL and testbench

CMD_DRAW_EDGES -- requirements
Module: cmd_draw_edges

---
 rtl/cmd_draw_edges.sv | 223 ++++++++++++++++++++++
 tb/tb_cmd_draw_edges.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_draw_edges.sv
`default_nettype none
// ============================================================================
// Module   : cmd_draw_edges
// Brief    : Walks an edge list, fetches both endpoints from the vertex list and
//            rasterises each edge with Bresenham into VRAM port B.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_draw_edges #(
    parameter int DEPTH      = 1024,
    parameter int FB_W       = 256,
    parameter int FB_H       = 192,
    parameter int SIDE_BYTES = 49152
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        draw_req_pulse,
    input  logic [10:0] edge_count,
    input  logic        side,
    output logic [9:0]  edge_raddr,
    input  logic [47:0] edge_q,
    output logic [9:0]  vertex_raddr,
    input  logic [63:0] vertex_q,
    output logic [17:0] vram_addr_b,
    output logic [7:0]  vram_data_b,
    output logic        vram_we_b,
    input  logic        vram_stall,
    output logic        BUSY,
    output logic        err_range
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RD_E  = 3'd1;
    localparam logic [2:0] c_ST_RD_V0 = 3'd2;
    localparam logic [2:0] c_ST_RD_V1 = 3'd3;
    localparam logic [2:0] c_ST_SETUP = 3'd4;
    localparam logic [2:0] c_ST_STEP  = 3'd5;

    logic [2:0]         r_state;
    logic               r_phase;
    logic               r_target;
    logic [10:0]        r_count;
    logic [10:0]        r_edge_idx;
    logic [9:0]         r_v1;
    logic [7:0]         r_colour;
    logic signed [15:0] r_x0, r_y0, r_x1, r_y1;
    logic signed [15:0] r_x, r_y;
    logic signed [17:0] r_dx, r_dy, r_err;
    logic               r_sx_neg, r_sy_neg;

    logic signed [18:0] w_e2, w_dx19, w_dy19;
    logic               w_x_move, w_y_move, w_last, w_count_bad;
    logic signed [17:0] w_err_next, w_ddx, w_ddy, w_adx, w_ady;
    logic signed [15:0] w_nx, w_ny;
    logic [10:0]        w_idx_next;
    logic               w_unused_bits;

    assign w_unused_bits = ^{edge_q[47:40], edge_q[31:26], edge_q[15:10], vertex_q[63:32]};

    function automatic logic f_in_frame(input logic signed [15:0] x, input logic signed [15:0] y);
        return (int'(x) >= 0) && (int'(x) < FB_W) && (int'(y) >= 0) && (int'(y) < FB_H);
    endfunction

    // Out-of-frame coordinates still produce an address; it is simply never written.
    function automatic logic [17:0] f_pix_addr(input logic tgt, input logic signed [15:0] x,
                                               input logic signed [15:0] y);
        int w_sum;
        w_sum = (tgt ? SIDE_BYTES : 0) + int'(y) * FB_W + int'(x);
        return w_sum[17:0];
    endfunction

    always_comb begin
        w_e2     = {r_err, 1'b0};
        w_dx19   = {r_dx[17], r_dx};
        w_dy19   = {r_dy[17], r_dy};
        w_x_move = (w_e2 >= w_dy19);
        w_y_move = (w_e2 <= w_dx19);
        w_err_next = r_err;
        w_nx = r_x;
        w_ny = r_y;
        if (w_x_move) begin
            w_err_next = w_err_next + r_dy;
            w_nx = r_sx_neg ? r_x - 16'sd1 : r_x + 16'sd1;
        end
        if (w_y_move) begin
            w_err_next = w_err_next + r_dx;
            w_ny = r_sy_neg ? r_y - 16'sd1 : r_y + 16'sd1;
        end
        w_last = (r_x == r_x1) && (r_y == r_y1);
        w_ddx  = {{2{r_x1[15]}}, r_x1} - {{2{r_x0[15]}}, r_x0};
        w_ddy  = {{2{r_y1[15]}}, r_y1} - {{2{r_y0[15]}}, r_y0};
        w_adx  = w_ddx[17] ? -w_ddx : w_ddx;
        w_ady  = w_ddy[17] ? -w_ddy : w_ddy;
        w_idx_next  = r_edge_idx + 11'd1;
        w_count_bad = (r_count == 11'd0) || (int'(r_count) > DEPTH);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_phase      <= 1'b0;
            r_target     <= 1'b0;
            r_count      <= '0;
            r_edge_idx   <= '0;
            r_v1         <= '0;
            r_colour     <= '0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_x1         <= '0;
            r_y1         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_err        <= '0;
            r_sx_neg     <= 1'b0;
            r_sy_neg     <= 1'b0;
            edge_raddr   <= '0;
            vertex_raddr <= '0;
            vram_addr_b  <= '0;
            vram_data_b  <= '0;
            vram_we_b    <= 1'b0;
            BUSY         <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    vram_we_b <= 1'b0;
                    if (draw_req_pulse) begin
                        r_target   <= ~side;
                        r_count    <= edge_count;
                        err_range  <= (int'(edge_count) > DEPTH);
                        BUSY       <= 1'b1;
                        r_edge_idx <= '0;
                        edge_raddr <= '0;
                        r_phase    <= 1'b0;
                        r_state    <= c_ST_RD_E;
                    end
                end
                // Empty or oversize requests bail out here, giving exactly one BUSY cycle.
                c_ST_RD_E: begin
                    if (!r_phase) begin
                        if (w_count_bad) begin
                            BUSY    <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_phase <= 1'b1;
                        end
                    end else begin
                        r_v1         <= edge_q[25:16];
                        r_colour     <= edge_q[39:32];
                        vertex_raddr <= edge_q[9:0];
                        r_phase      <= 1'b0;
                        r_state      <= c_ST_RD_V0;
                    end
                end
                c_ST_RD_V0: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_x0         <= vertex_q[15:0];
                        r_y0         <= vertex_q[31:16];
                        vertex_raddr <= r_v1;
                        r_phase      <= 1'b0;
                        r_state      <= c_ST_RD_V1;
                    end
                end
                c_ST_RD_V1: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_x1    <= vertex_q[15:0];
                        r_y1    <= vertex_q[31:16];
                        r_phase <= 1'b0;
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    r_dx        <= w_adx;
                    r_dy        <= -w_ady;
                    r_err       <= w_adx - w_ady;
                    r_sx_neg    <= (r_x1 < r_x0);
                    r_sy_neg    <= (r_y1 < r_y0);
                    r_x         <= r_x0;
                    r_y         <= r_y0;
                    vram_addr_b <= f_pix_addr(r_target, r_x0, r_y0);
                    vram_data_b <= r_colour;
                    vram_we_b   <= f_in_frame(r_x0, r_y0);
                    r_state     <= c_ST_STEP;
                end
                // The pixel on the bus is consumed on a non-stalled cycle; the next one is queued.
                c_ST_STEP: begin
                    if (!vram_stall) begin
                        if (w_last) begin
                            vram_we_b <= 1'b0;
                            if (w_idx_next == r_count) begin
                                BUSY    <= 1'b0;
                                r_state <= c_ST_IDLE;
                            end else begin
                                r_edge_idx <= w_idx_next;
                                edge_raddr <= w_idx_next[9:0];
                                r_phase    <= 1'b0;
                                r_state    <= c_ST_RD_E;
                            end
                        end else begin
                            r_err       <= w_err_next;
                            r_x         <= w_nx;
                            r_y         <= w_ny;
                            vram_addr_b <= f_pix_addr(r_target, w_nx, w_ny);
                            vram_we_b   <= f_in_frame(w_nx, w_ny);
                        end
                    end
                end
                default: begin
                    vram_we_b <= 1'b0;
                    BUSY      <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_draw_edges.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_draw_edges
// Brief    : Directed vectors, corner sequences and random edge lists for
//            cmd_draw_edges, checked against a Bresenham pixel-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_draw_edges;

    localparam int c_LIMIT = 20000;

    logic        CLK = 1'b0;
    logic        rst, draw_req_pulse, side, vram_stall;
    logic [10:0] edge_count;
    logic [9:0]  edge_raddr, vertex_raddr;
    logic [47:0] edge_q;
    logic [63:0] vertex_q;
    logic [17:0] vram_addr_b;
    logic [7:0]  vram_data_b;
    logic        vram_we_b, BUSY, err_range;

    logic [47:0] edge_mem [0:1023];
    logic [63:0] vert_mem [0:1023];
    int got_q[$];
    int exp_q[$];
    int checks = 0;
    int errors = 0;
    bit rand_stall = 1'b0;

    typedef struct {
        int x0, y0, x1, y1;
        bit sd;
        int col;
        bit same;
        int n;
        int a[5];
    } vec_t;
    vec_t tbl[7];

    always #5 CLK = ~CLK;

    cmd_draw_edges #(.DEPTH(1024), .FB_W(256), .FB_H(192), .SIDE_BYTES(49152)) dut (
        .CLK(CLK), .rst(rst), .draw_req_pulse(draw_req_pulse), .edge_count(edge_count),
        .side(side), .edge_raddr(edge_raddr), .edge_q(edge_q), .vertex_raddr(vertex_raddr),
        .vertex_q(vertex_q), .vram_addr_b(vram_addr_b), .vram_data_b(vram_data_b),
        .vram_we_b(vram_we_b), .vram_stall(vram_stall), .BUSY(BUSY), .err_range(err_range)
    );

    always @(posedge CLK) begin
        edge_q   <= edge_mem[edge_raddr];
        vertex_q <= vert_mem[vertex_raddr];
    end

    // A write lands on any cycle with we high and no stall.
    always @(negedge CLK)
        if (vram_we_b === 1'b1 && vram_stall === 1'b0)
            got_q.push_back(int'({vram_addr_b, vram_data_b}));

    initial begin
        vram_stall = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (rand_stall) vram_stall = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mkv(input int x, input int y);
        logic [31:0] junk;
        junk = $urandom;
        return {junk, y[15:0], x[15:0]};
    endfunction

    function automatic logic [47:0] mke(input int v0, input int v1, input int col);
        logic [31:0] junk;
        junk = $urandom;
        return {junk[7:0], col[7:0], junk[13:8], v1[9:0], junk[19:14], v0[9:0]};
    endfunction

    function automatic vec_t mkvec(input int x0, input int y0, input int x1, input int y1,
                                   input bit sd, input int col, input bit same, input int n,
                                   input int a0, input int a1, input int a2, input int a3, input int a4);
        vec_t v;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1;
        v.sd = sd; v.col = col; v.same = same; v.n = n;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3; v.a[4] = a4;
        return v;
    endfunction

    // Reference: enumerate the line's pixels with integer Bresenham, keep the on-screen ones.
    function automatic void model_edge(input int x0, input int y0, input int x1, input int y1,
                                       input int tgt, input int col);
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        for (int n = 0; n < 200000; n++) begin
            if (x >= 0 && x < 256 && y >= 0 && y < 192)
                exp_q.push_back(((tgt * 49152 + y * 256 + x) << 8) | col);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    function automatic void model_from_mem(input int count, input bit sd);
        logic [47:0] e;
        logic [63:0] p0, p1;
        exp_q.delete();
        for (int i = 0; i < count; i++) begin
            e  = edge_mem[i];
            p0 = vert_mem[e[9:0]];
            p1 = vert_mem[e[25:16]];
            model_edge(int'($signed(p0[15:0])), int'($signed(p0[31:16])),
                       int'($signed(p1[15:0])), int'($signed(p1[31:16])),
                       sd ? 0 : 1, int'(e[39:32]));
        end
    endfunction

    task automatic do_draw(input int count, input bit sd, input bit poke, input string name);
        int cyc;
        got_q.delete();
        @(posedge CLK); #1;
        side = sd; edge_count = 11'(count); draw_req_pulse = 1'b1;
        @(posedge CLK); #1;
        draw_req_pulse = 1'b0;
        cyc = 0;
        while (BUSY && cyc < c_LIMIT) begin
            if (poke && cyc == 4) begin
                draw_req_pulse = 1'b1; edge_count = 11'd0; side = ~sd;
            end else begin
                draw_req_pulse = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        draw_req_pulse = 1'b0;
        check({name, " done"}, 64'(cyc < c_LIMIT), 64'd1);
    endtask

    task automatic compare(input string name);
        check({name, " nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s px%0d", name, i), got_q[i], exp_q[i]);
    endtask

    task automatic pulse_count(input int count, output int busy_cyc, output logic er);
        got_q.delete();
        @(posedge CLK); #1;
        edge_count = 11'(count); draw_req_pulse = 1'b1;
        @(posedge CLK); #1;
        draw_req_pulse = 1'b0;
        er = err_range;
        busy_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            if (BUSY) busy_cyc++;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        int busy_cyc, cyc, n;
        logic er;
        logic [26:0] snap;
        bit sd;

        for (int i = 0; i < 1024; i++) begin
            edge_mem[i] = '0;
            vert_mem[i] = '0;
        end
        // Expected x for (0,0)->(2,4) follows the rule that e2 >= dy moves x first.
        tbl[0] = mkvec(0, 0, 3, 0, 1'b1, 'h1F, 1'b0, 4, 0, 1, 2, 3, 0);
        tbl[1] = mkvec(0, 0, 2, 4, 1'b0, 'h5A, 1'b0, 5, 49152, 49409, 49665, 49922, 50178);
        tbl[2] = mkvec(-2, 5, 2, 5, 1'b1, 'h33, 1'b0, 3, 1280, 1281, 1282, 0, 0);
        tbl[3] = mkvec(10, 10, 10, 10, 1'b1, 'h77, 1'b0, 1, 2570, 0, 0, 0, 0);
        tbl[4] = mkvec(10, 10, 50, 60, 1'b0, 'h81, 1'b1, 1, 51722, 0, 0, 0, 0);
        tbl[5] = mkvec(300, 5, 310, 5, 1'b1, 'h99, 1'b0, 0, 0, 0, 0, 0, 0);
        tbl[6] = mkvec(5, 2, 5, -2, 1'b1, 'hC4, 1'b0, 3, 517, 261, 5, 0, 0);

        rst = 1'b1; draw_req_pulse = 1'b0; side = 1'b0; edge_count = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst BUSY", BUSY, 0);
        check("rst err_range", err_range, 0);
        check("rst we", vram_we_b, 0);
        check("rst vram_addr", vram_addr_b, 0);
        check("rst vram_data", vram_data_b, 0);
        check("rst edge_raddr", edge_raddr, 0);
        check("rst vertex_raddr", vertex_raddr, 0);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            vert_mem[0] = mkv(tbl[t].x0, tbl[t].y0);
            vert_mem[1] = mkv(tbl[t].x1, tbl[t].y1);
            edge_mem[0] = mke(0, tbl[t].same ? 0 : 1, tbl[t].col);
            exp_q.delete();
            for (int k = 0; k < tbl[t].n; k++) exp_q.push_back((tbl[t].a[k] << 8) | tbl[t].col);
            do_draw(1, tbl[t].sd, 1'b0, $sformatf("vec%0d", t));
            compare($sformatf("vec%0d", t));
        end

        pulse_count(0, busy_cyc, er);
        check("cnt0 busy cycles", busy_cyc, 1);
        check("cnt0 err_range", er, 0);
        check("cnt0 nwrites", got_q.size(), 0);
        pulse_count(1025, busy_cyc, er);
        check("cnt1025 busy cycles", busy_cyc, 1);
        check("cnt1025 err_range", er, 1);
        check("cnt1025 sticky", err_range, 1);
        check("cnt1025 nwrites", got_q.size(), 0);

        vert_mem[0] = mkv(0, 0); vert_mem[1] = mkv(9, 0);
        edge_mem[0] = mke(0, 1, 'h42);
        model_from_mem(1, 1'b1);
        do_draw(1, 1'b1, 1'b0, "clear");
        check("err_range cleared", err_range, 0);
        compare("clear");

        got_q.delete();
        @(posedge CLK); #1;
        side = 1'b1; edge_count = 11'd1; draw_req_pulse = 1'b1;
        @(posedge CLK); #1;
        draw_req_pulse = 1'b0;
        cyc = 0;
        while (got_q.size() < 3 && cyc < 100) begin @(posedge CLK); #1; cyc++; end
        check("stall reach", 64'(cyc < 100), 64'd1);
        vram_stall = 1'b1;
        snap = {vram_addr_b, vram_data_b, vram_we_b};
        check("stall we", vram_we_b, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check($sformatf("stall hold%0d", k), {vram_addr_b, vram_data_b, vram_we_b}, snap);
            @(posedge CLK); #1;
        end
        vram_stall = 1'b0;
        cyc = 0;
        while (BUSY && cyc < 100) begin @(posedge CLK); #1; cyc++; end
        check("stall done", 64'(cyc < 100), 64'd1);
        compare("stall");

        vert_mem[0] = mkv(20, 30); vert_mem[1] = mkv(60, 40); vert_mem[2] = mkv(10, 150);
        edge_mem[0] = mke(0, 1, 'h11);
        edge_mem[1] = mke(1, 2, 'h22);
        model_from_mem(2, 1'b0);
        do_draw(2, 1'b0, 1'b1, "poke");
        compare("poke");

        vert_mem[0] = mkv(0, 100); vert_mem[1] = mkv(255, 100);
        edge_mem[0] = mke(0, 1, 'hE7);
        got_q.delete();
        @(posedge CLK); #1;
        side = 1'b0; edge_count = 11'd1; draw_req_pulse = 1'b1;
        @(posedge CLK); #1;
        draw_req_pulse = 1'b0;
        cyc = 0;
        while (got_q.size() < 5 && cyc < 100) begin @(posedge CLK); #1; cyc++; end
        check("rststep reach", 64'(cyc < 100), 64'd1);
        rst = 1'b1;
        @(posedge CLK); #1;
        check("rststep we", vram_we_b, 0);
        check("rststep BUSY", BUSY, 0);
        check("rststep addr", vram_addr_b, 0);
        check("rststep data", vram_data_b, 0);
        rst = 1'b0;
        model_from_mem(1, 1'b0);
        do_draw(1, 1'b0, 1'b0, "after rst");
        compare("after rst");

        rand_stall = 1'b1;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                vert_mem[2 * i]     = mkv($urandom_range(0, 315) - 30, $urandom_range(0, 250) - 30);
                vert_mem[2 * i + 1] = mkv($urandom_range(0, 315) - 30, $urandom_range(0, 250) - 30);
                edge_mem[i] = mke(2 * i, ($urandom_range(0, 5) == 0) ? 2 * i : 2 * i + 1,
                                  $urandom_range(0, 255));
            end
            sd = 1'($urandom_range(0, 1));
            model_from_mem(n, sd);
            do_draw(n, sd, 1'b0, $sformatf("rand%0d", r));
            compare($sformatf("rand%0d", r));
        end
        rand_stall = 1'b0;
        @(posedge CLK); #1;
        vram_stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
